// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared widths, stall encoding and bus layouts for the MEM stage.
//
// Contents:
//   EX_TO_MEM_WD, LOAD_SRAM_DATA_WD, MEM_TO_WB_WD, MEM_TO_ID_WD : bus widths
//   STALL_BUS, STOP, NO_STOP                                     : stall vector encoding
//   ex_to_mem_t  : field view of the EX->MEM bus
//   load_flags_t : one-hot load-type flags {lb, lbu, lh, lhu, lw}
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD      = 76;
  localparam int LOAD_SRAM_DATA_WD = 5;
  localparam int MEM_TO_WB_WD      = 70;
  localparam int MEM_TO_ID_WD      = 38;
  localparam int STALL_BUS         = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
  } load_flags_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- EX->MEM inputs, SRAM read data and MEM->WB/ID outputs of the MEM stage.
//
// Signals:
//   ex_to_mem_bus     [75:0] EX->MEM bus
//   load_sram_ex_data [4:0]  load-type flags from EX
//   data_ram_sel      [3:0]  byte-lane select from EX
//   data_sram_rdata   [31:0] synchronous SRAM read data
//   mem_to_wb_bus     [69:0] {pc, rf_we, rf_waddr, rf_wdata} to WB
//   mem_to_id_bus     [37:0] {rf_we, rf_waddr, rf_wdata} forwarding to ID
//   mem_adel                 misaligned-load flag
// Modports: master = upstream/environment side, slave = mem_stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [EX_TO_MEM_WD-1:0]      ex_to_mem_bus;
  logic [LOAD_SRAM_DATA_WD-1:0] load_sram_ex_data;
  logic [3:0]                   data_ram_sel;
  logic [31:0]                  data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0]      mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0]      mem_to_id_bus;
  logic                         mem_adel;

  modport master (
    output ex_to_mem_bus, load_sram_ex_data, data_ram_sel, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_bus, mem_adel
  );

  modport slave (
    input  ex_to_mem_bus, load_sram_ex_data, data_ram_sel, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_bus, mem_adel
  );

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align -- combinational load-data extraction for the MEM stage.
//
// Ports:
//   flags      in  load_flags_t  one-hot {lb, lbu, lh, lhu, lw}
//   sel        in  [3:0]         byte-lane select
//   rdata      in  [31:0]        effective SRAM read word
//   load_value out [31:0]        selected and extended load result
// Unlisted sel patterns or no flag set give 0.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  load_flags_t flags,
  input  logic [3:0]  sel,
  input  logic [31:0] rdata,
  output logic [31:0] load_value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        byte_ok;
  logic        half_ok;

  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    byte_v     = '0;
    half_v     = '0;
    byte_ok    = 1'b0;
    half_ok    = 1'b0;
    load_value = '0;

    case (sel)
      4'b0001: begin byte_v = rdata[7:0];   byte_ok = 1'b1; end
      4'b0010: begin byte_v = rdata[15:8];  byte_ok = 1'b1; end
      4'b0100: begin byte_v = rdata[23:16]; byte_ok = 1'b1; end
      4'b1000: begin byte_v = rdata[31:24]; byte_ok = 1'b1; end
      default: ;
    endcase

    case (sel)
      4'b0011: begin half_v = rdata[15:0];  half_ok = 1'b1; end
      4'b1100: begin half_v = rdata[31:16]; half_ok = 1'b1; end
      default: ;
    endcase

    if (flags.lw) begin
      load_value = rdata;
    end else if (flags.lh && half_ok) begin
      load_value = {{16{half_v[15]}}, half_v};
    end else if (flags.lhu && half_ok) begin
      load_value = {16'b0, half_v};
    end else if (flags.lb && byte_ok) begin
      load_value = {{24{byte_v[7]}}, byte_v};
    end else if (flags.lbu && byte_ok) begin
      load_value = {24'b0, byte_v};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline MEM stage: registers the EX->MEM bus, extracts load data
// from the synchronous data SRAM and drives the WB and ID-forwarding buses.
//
// Ports:
//   clk    in  clock
//   rst    in  synchronous, active-high reset
//   stall  in  [5:0] global stall vector; stall[3] = this stage, stall[4] = WB
//   bus    mem_stage_if.slave (EX bus, load flags, lane select, SRAM rdata in;
//          mem_to_wb_bus, mem_to_id_bus, mem_adel out)
//
// Optional feature: define MEM_UNALIGNED_CHECK_EN to flag misaligned lh/lhu/lw
// on mem_adel and suppress their register write; otherwise mem_adel is 0.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_BUS-1:0] stall,
  mem_stage_if.slave           bus
);

  ex_to_mem_t  ex_in;
  ex_to_mem_t  ex_q;
  load_flags_t load_q;
  logic [3:0]  sel_q;
  logic [31:0] rdata_q;
  logic        hold_v;

  logic        stop_mem;
  logic        stop_wb;
  logic        bubble;
  logic        capture;

  logic [31:0] rdata_eff;
  logic [31:0] load_value;
  logic [31:0] rf_wdata;
  logic        adel;
  logic        rf_we_out;

  assign ex_in    = ex_to_mem_t'(bus.ex_to_mem_bus);
  assign stop_mem = (stall[3] == STOP);
  assign stop_wb  = (stall[4] == STOP);
  assign bubble   = stop_mem && !stop_wb;
  assign capture  = !stop_mem;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      load_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      hold_v  <= 1'b0;
    end else if (bubble) begin
      ex_q    <= '0;
      load_q  <= '0;
      sel_q   <= '0;
      hold_v  <= 1'b0;
    end else if (capture) begin
      ex_q    <= ex_in;
      load_q  <= load_flags_t'(bus.load_sram_ex_data);
      sel_q   <= bus.data_ram_sel;
      hold_v  <= 1'b0;
    end else if (!hold_v) begin
      // First stalled cycle: the SRAM word for this load is on the bus now and
      // may change afterwards, so freeze it.
      rdata_q <= bus.data_sram_rdata;
      hold_v  <= 1'b1;
    end
  end

  assign rdata_eff = hold_v ? rdata_q : bus.data_sram_rdata;

  mem_load_align u_load_align (
    .flags      (load_q),
    .sel        (sel_q),
    .rdata      (rdata_eff),
    .load_value (load_value)
  );

  assign rf_wdata = ex_q.sel_rf_res ? load_value : ex_q.ex_result;

`ifdef MEM_UNALIGNED_CHECK_EN
  assign adel = ((load_q.lh || load_q.lhu) && ex_q.ex_result[0]) ||
                (load_q.lw && (ex_q.ex_result[1:0] != 2'b00));
`else
  assign adel = 1'b0;
`endif

  assign rf_we_out = ex_q.rf_we && !adel;

  assign bus.mem_to_wb_bus = {ex_q.pc, rf_we_out, ex_q.rf_waddr, rf_wdata};
  assign bus.mem_to_id_bus = {rf_we_out, ex_q.rf_waddr, rf_wdata};
  assign bus.mem_adel      = adel;

  // Store-side fields and other stages' stall bits are carried but not used here.
  logic unused_bits;
  assign unused_bits = ^{ex_q.ram_en, ex_q.ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage: directed load/stall/bubble/
// reset scenarios followed by randomized traffic against a behavioural model.
// Honours MEM_UNALIGNED_CHECK_EN the same way as the design.
module tb_mem_stage;

  localparam logic [4:0] F_LB  = 5'b10000;
  localparam logic [4:0] F_LBU = 5'b01000;
  localparam logic [4:0] F_LH  = 5'b00100;
  localparam logic [4:0] F_LHU = 5'b00010;
  localparam logic [4:0] F_LW  = 5'b00001;

  typedef struct packed {
    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [3:0]  sel;
  } inst_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus currently applied
  inst_t       cur_inst;
  logic [4:0]  cur_store_bits;
  logic [31:0] cur_rdata;
  logic [5:0]  cur_stall;
  logic        cur_rst;

  // Reference model state: the instruction sitting in MEM and the read word
  // frozen during a stall.
  inst_t       m_inst;
  logic        m_frozen_v;
  logic [31:0] m_frozen;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rst   = cur_rst;
    stall = cur_stall;
    bus_if.ex_to_mem_bus = {cur_inst.pc, cur_store_bits, cur_inst.sel_rf_res,
                            cur_inst.rf_we, cur_inst.rf_waddr, cur_inst.result};
    bus_if.load_sram_ex_data = cur_inst.flags;
    bus_if.data_ram_sel      = cur_inst.sel;
    bus_if.data_sram_rdata   = cur_rdata;
  endtask

  // Load value from the spec's rules: locate the lane by its offset, shift it down,
  // mask and extend.
  function automatic logic [31:0] ref_load(logic [4:0] flags, logic [3:0] sel, logic [31:0] rd);
    int off;
    logic [31:0] v;
    off = -1;
    v   = '0;
    if (flags == F_LW) return rd;
    if (flags == F_LB || flags == F_LBU) begin
      for (int i = 0; i < 4; i++) if (sel == (4'b0001 << i)) off = 8 * i;
      if (off < 0) return 32'h0;
      v = (rd >> off) & 32'hFF;
      if (flags == F_LB && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (flags == F_LH || flags == F_LHU) begin
      if (sel == 4'b0011) off = 0;
      else if (sel == 4'b1100) off = 16;
      else return 32'h0;
      v = (rd >> off) & 32'hFFFF;
      if (flags == F_LH && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    return 32'h0;
  endfunction

  function automatic logic ref_adel(inst_t i);
`ifdef MEM_UNALIGNED_CHECK_EN
    return ((i.flags == F_LH || i.flags == F_LHU) && i.result[0]) ||
           (i.flags == F_LW && i.result[1:0] != 2'b00);
`else
    return (i.flags == 5'h1F) && 1'b0;
`endif
  endfunction

  task automatic update_model();
    if (cur_rst) begin
      m_inst     = '0;
      m_frozen_v = 1'b0;
    end else if (cur_stall[3] && !cur_stall[4]) begin
      m_inst     = '0;
      m_frozen_v = 1'b0;
    end else if (!cur_stall[3]) begin
      m_inst     = cur_inst;
      m_frozen_v = 1'b0;
    end else if (!m_frozen_v) begin
      m_frozen   = cur_rdata;
      m_frozen_v = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] wdata;
    logic        adel;
    logic        we;
    #1;
    wdata = m_inst.sel_rf_res ?
            ref_load(m_inst.flags, m_inst.sel, m_frozen_v ? m_frozen : cur_rdata) :
            m_inst.result;
    adel = ref_adel(m_inst);
    we   = m_inst.rf_we & ~adel;
    check({tag, "_wb"}, 70'(bus_if.mem_to_wb_bus), {m_inst.pc, we, m_inst.rf_waddr, wdata});
    check({tag, "_id"}, 70'(bus_if.mem_to_id_bus), 70'({we, m_inst.rf_waddr, wdata}));
    check({tag, "_adel"}, 70'(bus_if.mem_adel), 70'(adel));
  endtask

  task automatic set_inst(input logic [4:0] flags, input logic [3:0] sel,
                          input logic [31:0] result, input logic sel_rf_res,
                          input logic [4:0] waddr, input logic [31:0] pc);
    cur_inst.flags      = flags;
    cur_inst.sel        = sel;
    cur_inst.result     = result;
    cur_inst.sel_rf_res = sel_rf_res;
    cur_inst.rf_we      = 1'b1;
    cur_inst.rf_waddr   = waddr;
    cur_inst.pc         = pc;
    drive();
  endtask

  task automatic set_rdata(input logic [31:0] d);
    cur_rdata = d;
    drive();
  endtask

  task automatic set_stall(input logic [5:0] s);
    cur_stall = s;
    drive();
  endtask

  task automatic random_inst();
    int kind;
    kind = $urandom_range(0, 5);
    cur_inst.pc       = $urandom;
    cur_inst.rf_we    = 1'($urandom_range(0, 1));
    cur_inst.rf_waddr = 5'($urandom);
    cur_inst.result   = $urandom;
    if ($urandom_range(0, 1) == 0) cur_inst.result[1:0] = 2'b00;
    case (kind)
      1: begin cur_inst.flags = F_LB;  cur_inst.sel = 4'b0001 << $urandom_range(0, 3); end
      2: begin cur_inst.flags = F_LBU; cur_inst.sel = 4'b0001 << $urandom_range(0, 3); end
      3: begin cur_inst.flags = F_LH;  cur_inst.sel = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1100; end
      4: begin cur_inst.flags = F_LHU; cur_inst.sel = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1100; end
      5: begin cur_inst.flags = F_LW;  cur_inst.sel = 4'b1111; end
      default: begin cur_inst.flags = 5'b0; cur_inst.sel = 4'($urandom); end
    endcase
    if ($urandom_range(0, 7) == 0) cur_inst.sel = 4'($urandom);
    cur_inst.sel_rf_res = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cur_store_bits = 5'($urandom);
  endtask

  logic        exp_adel;
  logic [69:0] wb_now;

  initial begin
    cur_inst       = '0;
    cur_store_bits = '0;
    cur_rdata      = 32'hDEAD_BEEF;
    cur_stall      = '0;
    cur_rst        = 1'b1;
    m_inst         = '0;
    m_frozen_v     = 1'b0;
    m_frozen       = '0;
    drive();

    // Reset
    step();
    step();
    cur_rst = 1'b0;
    drive();
    #1;
    check("reset_wb", 70'(bus_if.mem_to_wb_bus), 70'h0);
    check("reset_id", 70'(bus_if.mem_to_id_bus), 70'h0);
    check("reset_adel", 70'(bus_if.mem_adel), 70'h0);

    // lb / lbu from lane 2
    set_inst(F_LB, 4'b0100, 32'h0000_1002, 1'b1, 5'd5, 32'hBFC0_0000);
    step();
    set_rdata(32'h1285_3456);
    #1;
    wb_now = bus_if.mem_to_wb_bus;
    check("lb_wdata", 70'(wb_now[31:0]), 70'hFFFF_FF85);
    check("lb_we", 70'(wb_now[37]), 70'h1);
    check_model("lb");

    set_inst(F_LBU, 4'b0100, 32'h0000_1002, 1'b1, 5'd6, 32'hBFC0_0004);
    step();
    set_rdata(32'h1285_3456);
    #1;
    check("lbu_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h0000_0085);

    // lhu upper half / lh lower half
    set_inst(F_LHU, 4'b1100, 32'h0000_1002, 1'b1, 5'd7, 32'hBFC0_0008);
    step();
    set_rdata(32'h8001_7FFF);
    #1;
    check("lhu_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h0000_8001);

    set_inst(F_LH, 4'b0011, 32'h0000_1000, 1'b1, 5'd8, 32'hBFC0_000C);
    step();
    set_rdata(32'h8001_7FFF);
    #1;
    check("lh_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h0000_7FFF);

    // lw held through a stall while the SRAM output moves on
    set_inst(F_LW, 4'b1111, 32'h0000_1000, 1'b1, 5'd9, 32'hBFC0_0010);
    step();
    set_rdata(32'hAAAA_0000);
    set_stall(6'b011000);
    #1;
    check("lw_stall_c1", 70'(bus_if.mem_to_wb_bus[31:0]), 70'hAAAA_0000);
    step();
    set_rdata(32'h0000_0001);
    #1;
    check("lw_stall_c2", 70'(bus_if.mem_to_wb_bus[31:0]), 70'hAAAA_0000);
    step();
    set_rdata(32'h0000_0002);
    #1;
    check("lw_stall_c3", 70'(bus_if.mem_to_wb_bus[31:0]), 70'hAAAA_0000);
    check_model("lw_stall");

    // Stall released; a non-load addu follows and forwards in the same cycle
    set_stall(6'b000000);
    set_inst(5'b0, 4'b0000, 32'h0000_1234, 1'b0, 5'd10, 32'hBFC0_0014);
    step();
    set_rdata(32'h5555_5555);
    #1;
    check("addu_wb_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h0000_1234);
    check("addu_id", 70'(bus_if.mem_to_id_bus), 70'({1'b1, 5'd10, 32'h0000_1234}));

    // Bubble: MEM stalled while WB runs
    set_inst(F_LW, 4'b1111, 32'h0000_2000, 1'b1, 5'd11, 32'hBFC0_0018);
    step();
    set_stall(6'b001000);
    step();
    #1;
    check("bubble_we", 70'(bus_if.mem_to_wb_bus[37]), 70'h0);
    set_stall(6'b000000);

    // Misaligned lw
    set_inst(F_LW, 4'b1111, 32'h0000_1002, 1'b1, 5'd12, 32'hBFC0_001C);
    step();
    set_rdata(32'h0BAD_F00D);
`ifdef MEM_UNALIGNED_CHECK_EN
    exp_adel = 1'b1;
`else
    exp_adel = 1'b0;
`endif
    #1;
    check("adel_flag", 70'(bus_if.mem_adel), 70'(exp_adel));
    check("adel_we", 70'(bus_if.mem_to_wb_bus[37]), 70'(!exp_adel));
    check("adel_id_we", 70'(bus_if.mem_to_id_bus[37]), 70'(!exp_adel));

    // Reset in the middle of a stall
    set_inst(F_LW, 4'b1111, 32'h0000_3000, 1'b1, 5'd13, 32'hBFC0_0020);
    step();
    set_stall(6'b011000);
    set_rdata(32'hCAFE_F00D);
    step();
    cur_rst = 1'b1;
    drive();
    step();
    #1;
    check("rst_stall_wb", 70'(bus_if.mem_to_wb_bus), 70'h0);
    check("rst_stall_id", 70'(bus_if.mem_to_id_bus), 70'h0);
    check("rst_stall_adel", 70'(bus_if.mem_adel), 70'h0);
    cur_rst = 1'b0;
    set_stall(6'b000000);

    // Instruction right after the reset is unaffected
    set_inst(F_LBU, 4'b0001, 32'h0000_3000, 1'b1, 5'd14, 32'hBFC0_0024);
    step();
    set_rdata(32'h0000_00F0);
    #1;
    check("post_rst_wdata", 70'(bus_if.mem_to_wb_bus[31:0]), 70'h0000_00F0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cur_rst   = ($urandom_range(0, 99) == 0);
      cur_stall = 6'($urandom);
      cur_stall[3] = ($urandom_range(0, 3) == 0);
      cur_stall[4] = ($urandom_range(0, 3) == 0);
      random_inst();
      cur_rdata = $urandom;
      drive();
      check_model("rand");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
